// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit: shift-add multiply and restoring divide,
// one step per clock, result returned to the register file as a one-cycle write strobe.
module muldiv_unit #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     result,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data
);

    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_op;
    logic [DATA_W-1:0]     r_a;      // multiplicand, or dividend shifting into quotient
    logic [DATA_W-1:0]     r_b;      // multiplier (shifts out MSB-first), or divisor
    logic [2*DATA_W-1:0]   r_acc;    // product, or remainder in the low DATA_W+1 bits
    logic [REG_ADDR_W-1:0] r_dest;

    logic [2*DATA_W-1:0]   w_mul_acc;
    logic [DATA_W:0]       w_shift;
    logic [DATA_W:0]       w_trial;
    logic                  w_q_bit;
    logic [DATA_W:0]       w_rem;
    logic [2*DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]     w_a_nxt;
    logic [DATA_W-1:0]     w_b_nxt;
    logic [DATA_W-1:0]     w_sel;

    assign w_mul_acc = {r_acc[2*DATA_W-2:0], 1'b0}
                     + (r_b[DATA_W-1] ? {{DATA_W{1'b0}}, r_a} : '0);

    assign w_shift = {r_acc[DATA_W-1:0], r_a[DATA_W-1]};
    assign w_trial = w_shift - {1'b0, r_b};
    assign w_q_bit = (w_shift >= {1'b0, r_b});
    assign w_rem   = w_q_bit ? w_trial : w_shift;

    always_comb begin
        w_acc_nxt = w_mul_acc;
        w_a_nxt   = r_a;
        w_b_nxt   = r_b << 1;
        if (r_op[1]) begin
            w_acc_nxt = {{(DATA_W-1){1'b0}}, w_rem};
            w_a_nxt   = {r_a[DATA_W-2:0], w_q_bit};
            w_b_nxt   = r_b;
        end
    end

    always_comb begin
        w_sel = '0;
        case (r_op)
            OP_MUL:  w_sel = w_acc_nxt[DATA_W-1:0];
            OP_MULH: w_sel = w_acc_nxt[2*DATA_W-1:DATA_W];
            OP_DIVU: w_sel = w_a_nxt;
            OP_REMU: w_sel = w_acc_nxt[DATA_W-1:0];
            default: w_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_dest     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= operand_a;
                        r_b     <= operand_b;
                        r_dest  <= dest_reg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_a   <= w_a_nxt;
                    r_b   <= w_b_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Final step publishes the result computed from this step's next values
                    if (r_cnt == CNT_W'(DATA_W-1)) begin
                        r_state    <= S_DONE;
                        done       <= 1'b1;
                        result     <= w_sel;
                        write_data <= w_sel;
                        write_reg  <= r_dest;
                        reg_write  <= (r_dest != '0);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    reg_write <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [2:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        reg_write;
    logic [2:0]  write_reg;
    logic [15:0] write_data;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_reg   (dest_reg),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation and checks the full E0..E17 timeline; poke injects ignored starts.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] d,
                          input logic [15:0] exp, input bit poke);
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
        @(posedge clk); #1;
        start = 1'b0; operand_a = ~a; operand_b = b ^ 16'h5A5A; op = ~o; dest_reg = 3'd6;
        check({tag, "_busy_E0"}, {31'd0, busy}, 32'd1);
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (poke && e == 4) begin
                start = 1'b1; op = 2'b00; operand_a = 16'h7777; operand_b = 16'h0003; dest_reg = 3'd5;
            end
            if (poke && e == 5) start = 1'b0;
            if (e == 15) check({tag, "_done_E15"}, {31'd0, done}, 32'd0);
        end
        check({tag, "_done"},      {31'd0, done},      32'd1);
        check({tag, "_busy_E16"},  {31'd0, busy},      32'd1);
        check({tag, "_result"},    {16'd0, result},    {16'd0, exp});
        check({tag, "_wdata"},     {16'd0, write_data},{16'd0, exp});
        check({tag, "_wreg"},      {29'd0, write_reg}, {29'd0, d});
        check({tag, "_regwrite"},  {31'd0, reg_write}, {31'd0, (d != 3'd0)});
        if (poke) begin
            start = 1'b1; op = 2'b00; operand_a = 16'h7777; operand_b = 16'h0003; dest_reg = 3'd5;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_E17"},  {31'd0, busy},      32'd0);
        check({tag, "_done_E17"},  {31'd0, done},      32'd0);
        check({tag, "_rw_E17"},    {31'd0, reg_write}, 32'd0);
        check({tag, "_hold"},      {16'd0, result},    {16'd0, exp});
        check({tag, "_hold_wreg"}, {29'd0, write_reg}, {29'd0, d});
    endtask

    initial begin
        int seen_done;
        reset = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; dest_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_done",   {31'd0, done},       32'd0);
        check("rst_rw",     {31'd0, reg_write},  32'd0);
        check("rst_result", {16'd0, result},     32'd0);
        check("rst_wreg",   {29'd0, write_reg},  32'd0);
        check("rst_wdata",  {16'd0, write_data}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mul",      2'b00, 16'h0123, 16'h0045, 3'd3, 16'h4E6F, 1'b0);
        run_op("mulh_ff",  2'b01, 16'hFFFF, 16'hFFFF, 3'd2, 16'hFFFE, 1'b0);
        run_op("mul_ff",   2'b00, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 1'b0);
        run_op("divu",     2'b10, 16'd1000, 16'd7,    3'd4, 16'h008E, 1'b0);
        run_op("remu",     2'b11, 16'd1000, 16'd7,    3'd1, 16'h0006, 1'b0);
        run_op("divu_z",   2'b10, 16'h1234, 16'h0000, 3'd7, 16'hFFFF, 1'b0);
        run_op("remu_z",   2'b11, 16'h1234, 16'h0000, 3'd7, 16'h1234, 1'b0);
        run_op("busy_ign", 2'b00, 16'h0010, 16'h0020, 3'd3, 16'h0200, 1'b1);
        run_op("dest0",    2'b01, 16'h8000, 16'h0004, 3'd0, 16'h0002, 1'b0);

        // Reset during RUN, asserted so the edge E8 samples it
        start = 1'b1; op = 2'b00; operand_a = 16'h00FF; operand_b = 16'h00FF; dest_reg = 3'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy",   {31'd0, busy},       32'd0);
        check("mrst_done",   {31'd0, done},       32'd0);
        check("mrst_rw",     {31'd0, reg_write},  32'd0);
        check("mrst_result", {16'd0, result},     32'd0);
        check("mrst_wreg",   {29'd0, write_reg},  32'd0);
        check("mrst_wdata",  {16'd0, write_data}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || reg_write || busy) seen_done++;
        end
        check("mrst_quiet", seen_done, 32'd0);

        run_op("post_rst", 2'b00, 16'h00FF, 16'h00FF, 3'd2, 16'hFE01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
